// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Execute-stage HI/LO unit for the MIPS core. It performs single-cycle
// MULT/MULTU and MTHI/MTLO, and runs DIV/DIVU as a WIDTH-step restoring
// divider. While a division is in flight it holds the front of the pipeline
// with a stall. It also owns the architectural HI/LO registers and serves
// MFHI/MFLO reads combinationally.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic [1:0]       mfhi_lo,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_next;

  // Divider working registers. quo_q starts out holding the dividend
  // magnitude; quotient bits shift in from the right as dividend bits
  // shift out of the left and into the partial remainder.
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] raw_a_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div_zero_q;

  logic             accept;
  logic             is_div_op;
  logic             div_issue;
  logic             last_step;

  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  // Issue decode. Only an idle unit accepts work, and a flush in the same
  // cycle drops the instruction entirely, whatever its kind.
  always_comb begin
    accept    = (state == ST_IDLE) && start && !flush;
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    div_issue = accept && is_div_op;
    last_step = (state == ST_DIV) && (counter == LAST_STEP) && !flush;
  end

  // Pipeline hold. The issue cycle already stalls, so the DIV instruction
  // stays in EX until the DONE cycle. A flush releases the stall at once.
  always_comb begin
    stall = div_issue || ((state == ST_DIV) && !flush);
    busy  = (state == ST_DIV);
  end

  // Operand conditioning for DIV. The divider works on magnitudes, and the
  // sign flags are kept for the final fix-up.
  always_comb begin
    div_signed = (op == OP_DIV);
    a_neg      = div_signed && src_a[WIDTH-1];
    b_neg      = div_signed && src_b[WIDTH-1];
    a_mag      = a_neg ? (-src_a) : src_a;
    b_mag      = b_neg ? (-src_b) : src_b;
  end

  // Full-width products. Both operands are sign- or zero-extended to
  // 2*WIDTH bits first, so the low 2*WIDTH bits of the product are exact.
  always_comb begin
    prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
  end

  // One restoring step. Shift the next dividend bit into the remainder and
  // try to subtract the divisor. Keep the difference only if it did not
  // borrow. The remainder is always below the divisor, so a successful
  // difference fits in WIDTH bits.
  always_comb begin
    partial   = {rem_q, quo_q[WIDTH-1]};
    trial     = partial - {1'b0, divisor_q};
    rem_step  = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    quo_final = neg_quo_q ? (-quo_step) : quo_step;
    rem_final = neg_rem_q ? (-rem_step) : rem_step;
  end

  // Next-state logic. DONE lasts exactly one cycle, so the held DIV can
  // leave EX. A flush forces IDLE from any state.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      ST_IDLE: begin
        if (div_issue) begin
          state_next   = ST_DIV;
          counter_next = '0;
        end
      end
      ST_DIV: begin
        if (counter == LAST_STEP) begin
          state_next   = ST_DONE;
          counter_next = '0;
        end else begin
          counter_next = counter + 1'b1;
        end
      end
      ST_DONE: begin
        state_next   = ST_IDLE;
        counter_next = '0;
      end
      default: begin
        state_next   = ST_IDLE;
        counter_next = '0;
      end
    endcase
    if (flush) begin
      state_next   = ST_IDLE;
      counter_next = '0;
    end
  end

  // State and iteration counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  // Divider datapath. Operands are loaded on issue and advance one step per
  // DIV cycle. A flush simply abandons them.
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      raw_a_q    <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (div_issue) begin
      divisor_q  <= b_mag;
      rem_q      <= '0;
      quo_q      <= a_mag;
      raw_a_q    <= src_a;
      neg_quo_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      div_zero_q <= (src_b == '0);
    end else if ((state == ST_DIV) && !flush) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
    end
  end

  // Architectural HI/LO. Accepted multiplies and moves write at once. A
  // division writes on its final step. A zero divisor yields all-ones in LO
  // and the raw dividend in HI, whatever the signs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (accept) begin
      case (op)
        OP_MULT:  {hi, lo} <= prod_s;
        OP_MULTU: {hi, lo} <= prod_u;
        OP_MTHI:  hi <= src_a;
        OP_MTLO:  lo <= src_a;
        default: begin
        end
      endcase
    end else if (last_step) begin
      if (div_zero_q) begin
        lo <= '1;
        hi <= raw_a_q;
      end else begin
        lo <= quo_final;
        hi <= rem_final;
      end
    end
  end

  // MFHI/MFLO read port. It reads the registers directly, with no bypass.
  always_comb begin
    case (mfhi_lo)
      2'b10:   rdata = hi;
      2'b01:   rdata = lo;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit
// Drives directed and random HI/LO operations into hilo_muldiv_unit. Each
// issued operation pushes its expected HI/LO, and the cycle it should appear
// in, into a scoreboard queue. A monitor pops and compares entries as they
// come due. Expected values come from plain integer arithmetic.
module tb_hilo_muldiv_unit;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic [1:0]       mfhi_lo;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rdata;

  hilo_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .flush   (flush),
    .mfhi_lo (mfhi_lo),
    .stall   (stall),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rdata   (rdata)
  );

  typedef struct {
    int          due;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          cyc     = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: during the cycle after the k-th rising edge, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [63:0] refMul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint pa;
    longint pb;
    pa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    pb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(pa * pb);
  endfunction

  function automatic void refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sd;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      q  = 32'(sa / sd);
      r  = 32'(sa % sd);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic pushExpect(input int due);
    exp_t e;
    e.due    = due;
    e.exp_hi = m_hi;
    e.exp_lo = m_lo;
    sb.push_back(e);
  endtask

  // Monitor: compare HI/LO whenever the head expectation comes due.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkOutput("sb_due_cycle", 32'(cyc), 32'(e.due));
      checkOutput("sb_hi", hi, e.exp_hi);
      checkOutput("sb_lo", lo, e.exp_lo);
    end
  end

  // Issue one operation at the current cycle. A division holds start while
  // stalled, as the pipeline would, and measures the stall length.
  task automatic applyStimulus(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    int n;
    bit done;
    start = 1'b1;
    op    = opc;
    src_a = a;
    src_b = b;
    flush = 1'b0;
    if (opc == OP_DIV || opc == OP_DIVU) begin
      refDiv(opc == OP_DIV, a, b, q, r);
      m_lo = q;
      m_hi = r;
      pushExpect(cyc + 33);
      mfhi_lo = 2'b01;
      n = 0;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
        @(negedge clk);
        if (stall) begin
          n++;
          @(posedge clk);
          #1;
        end else begin
          done = 1;
        end
      end
      checkOutput("div_stall_len", 32'(n), 32'd33);
      checkOutput("div_done_busy", {31'b0, busy}, 32'd0);
      checkOutput("div_done_rdata", rdata, m_lo);
      @(posedge clk);
      #1;
      start = 1'b0;
    end else begin
      if (opc == OP_MULT || opc == OP_MULTU) {m_hi, m_lo} = refMul(opc == OP_MULT, a, b);
      else if (opc == OP_MTHI) m_hi = a;
      else if (opc == OP_MTLO) m_lo = a;
      pushExpect(cyc + 1);
      @(negedge clk);
      checkOutput("nodiv_stall", {31'b0, stall}, 32'd0);
      checkOutput("nodiv_busy", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  // Start with flush in the same cycle: the operation must be dropped.
  task automatic dropStimulus(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    flush = 1'b1;
    op    = opc;
    src_a = a;
    src_b = b;
    pushExpect(cyc + 1);
    @(negedge clk);
    checkOutput("drop_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
  endtask

  // Start a division, then kill it with flush or reset at a given iteration.
  task automatic abortDiv(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input int iter, input bit use_rst);
    start = 1'b1;
    op    = opc;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (iter) begin
      @(posedge clk);
      #1;
    end
    if (use_rst) begin
      rst  = 1'b1;
      m_hi = 32'd0;
      m_lo = 32'd0;
    end else begin
      flush = 1'b1;
    end
    pushExpect(cyc + 1);
    @(negedge clk);
    checkOutput("abort_busy_mid", {31'b0, busy}, 32'd1);
    if (!use_rst) checkOutput("flush_stall_same", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic checkRdata(input logic [1:0] sel);
    logic [31:0] req;
    mfhi_lo = sel;
    #1;
    req = (sel == 2'b10) ? m_hi : (sel == 2'b01) ? m_lo : 32'd0;
    checkOutput("rdata", rdata, req);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [2:0]  ropc;
    logic [31:0] ra;
    logic [31:0] rb;
    int          pick;
    rst     = 1'b1;
    start   = 1'b0;
    flush   = 1'b0;
    op      = 3'b000;
    src_a   = '0;
    src_b   = '0;
    mfhi_lo = 2'b00;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] multiply");
    applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    applyStimulus(OP_MULTU, 32'hFFFF_FFFE, 32'd3);

    $display("[TB] divide");
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    applyStimulus(OP_DIV, 32'h1234_5678, 32'd0);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(OP_DIV, 32'h8765_4321, 32'd0);

    $display("[TB] flush mid-division");
    applyStimulus(OP_MTHI, 32'hAAAA_0000, 32'd0);
    applyStimulus(OP_MTLO, 32'h0000_5555, 32'd0);
    abortDiv(OP_DIV, 32'd1000, 32'd7, 10, 1'b0);
    applyStimulus(OP_DIVU, 32'd9, 32'd3);

    $display("[TB] flush drops idle starts");
    dropStimulus(OP_MULT, 32'd12, 32'd34);
    dropStimulus(OP_MTHI, 32'h1111_2222, 32'd0);
    dropStimulus(OP_DIV, 32'd50, 32'd5);

    $display("[TB] move and read");
    applyStimulus(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    applyStimulus(OP_MTLO, 32'h0BAD_F00D, 32'd0);
    checkRdata(2'b10);
    checkRdata(2'b01);
    checkRdata(2'b00);
    checkRdata(2'b11);

    $display("[TB] reset mid-division");
    abortDiv(OP_DIVU, 32'hFFFF_0000, 32'd3, 20, 1'b1);
    applyStimulus(OP_MULTU, 32'd5, 32'd6);

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      ropc = 3'($urandom_range(0, 7));
      ra   = $urandom;
      pick = $urandom_range(0, 7);
      if (pick == 0) rb = 32'd0;
      else if (pick < 3) rb = 32'($urandom_range(1, 20));
      else if (pick == 3) rb = 32'hFFFF_FFFF;
      else rb = $urandom;
      applyStimulus(ropc, ra, rb);
      checkRdata(2'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
